alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station feeding the integer ALU in the out-of-order RISC-V core. It buffers decoded ALU/branch/jump instructions from the issue stage and snoops the ALU and load/store result broadcasts to capture pending operands. Each cycle it dispatches the oldest-indexed fully-ready entry to the ALU on the ALU's registered dispatch interface (alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos).

## Interface
- RS_SIZE, 16: number of entries (power of two, ≥2).
- ROB_POS_W, 4: ROB index width; must equal the width of `ROB_POS_WID`.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- rollback  in  1  misprediction flush; synchronous.
- issue_valid  in  1  new instruction presented this cycle.
- issue_opcode / issue_funct3 / issue_funct7  in  7/3/1  decoded fields.
- issue_val1, issue_val2  in  32 each  operand values, valid when the matching has_dep is 0.
- issue_has_dep1, issue_has_dep2  in  1 each  operand still pending.
- issue_dep1, issue_dep2  in  ROB_POS_W each  ROB tag of the pending producer.
- issue_imm, issue_pc  in  32 each  immediate and instruction address.
- issue_rob_pos  in  ROB_POS_W  destination ROB slot.
- rs_full  out  1  no free entry; issue must not assert issue_valid.
- alu_bc, alu_bc_rob_pos, alu_bc_val  in  1/ROB_POS_W/32  ALU result broadcast.
- lsb_bc, lsb_bc_rob_pos, lsb_bc_val  in  1/ROB_POS_W/32  load/store buffer result broadcast.
- alu_en  out  1  dispatch valid (registered).
- opcode, funct3, funct7, val1, val2, imm, pc, rob_pos  out  7/3/1/32/32/32/32/ROB_POS_W  dispatched fields (registered).

## Operation
- Entry state: busy, opcode, funct3, funct7, val1/2, has_dep1/2, dep1/2, imm, pc, rob_pos.
- Issue: on an edge with rdy=1, rollback=0, issue_valid=1, write to the lowest-index non-busy entry and set busy.
- Issue-time bypass: if issue_has_depN=1 and a broadcast in the same cycle carries rob_pos == issue_depN, store that value with has_depN=0.
- Wakeup: on each edge, every busy entry with has_depN=1 and depN equal to a valid broadcast tag captures the value and clears has_depN. ALU broadcast wins on a tag collision (should never occur).
- Ready: busy & !has_dep1 & !has_dep2, evaluated on registered state.
- Dispatch: the lowest-index ready entry drives the outputs; alu_en<=1 and that entry's busy is cleared on the same edge. No ready entry: alu_en<=0, other outputs hold.
- Issue and dispatch may occur in the same cycle; the freed slot becomes reusable one cycle later.
- rs_full = (busy count == RS_SIZE), computed combinationally from registered busy bits. issue_valid while rs_full is dropped, and simulation asserts an error.

## Timing
- Reset (async): all busy=0, alu_en=0, every output field 0, rs_full=0.
- rollback=1 at an edge: all busy cleared, alu_en<=0; issue, wakeup and dispatch that cycle are discarded. rollback takes priority over rdy.
- rdy=0: no state change; outputs hold; broadcasts that cycle are not captured (producers also stall).
- Latency: issue at edge N with no deps → alu_en high after edge N+1. Wakeup at edge N → dispatch at edge N+1 (see Configuration).
- At most one dispatch and one issue per cycle.

## Configuration
- ALU_RS_WAKEUP_DISPATCH_EN defined: ready also counts a dependency satisfied by a broadcast in the current cycle. The entry can dispatch on the wakeup edge, using the broadcast value forwarded to val1/val2. This is one cycle faster.
- Undefined: ready uses registered has_dep only, as in Operation.

## Structure
- Width macros come from Mydefine.v: `OP_WID`, `FUNCT3_WID`, `ROB_POS_WID`. Opcode constants also come from there. Add `RS_SIZE` and `RS_ID_WID` to it.
- Sub-module rs_prio_enc: a parameterised lowest-set-bit encoder (onehot in → index + found). It is instantiated twice, once for the free slot and once for dispatch select.

## Test plan
- Reset mid-stream with 3 busy entries and alu_en=1: all outputs 0 immediately, rs_full=0, next issue goes to entry 0.
- Issue ADDI (opcode 0010011, val1=5, imm=7, no deps, rob_pos=3): alu_en=1 one cycle later with val1=5, imm=7, rob_pos=3; alu_en=0 the cycle after.
- Issue ADD with dep1=2, then alu_bc=1/rob_pos=2/val=0x10 two cycles later: no dispatch before the broadcast; dispatch one cycle after it with val1=0x10. With the macro defined, dispatch happens on the broadcast edge.
- Issue with has_dep2=1 and dep2=6 in the same cycle as lsb_bc rob_pos=6, val=0xABCD: entry stores val2=0xABCD; dispatch follows next cycle.
- Fill 16 entries all blocked on tag 9: rs_full=1. Broadcast tag 9: entries dispatch in index order 0..15, one per cycle, and rs_full drops after the first dispatch.
- rollback with 4 busy entries and a concurrent issue: all entries empty, alu_en=0 next cycle, and the concurrent issue is not stored.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// ============================================================================
// Module      : alu_rs_pkg
// Description : Shared widths, opcode constants and operand-snoop helper for
//               the ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_rs_pkg;

    localparam int OP_WID      = 7;
    localparam int FUNCT3_WID  = 3;
    localparam int ROB_POS_WID = 4;
    localparam int RS_SIZE     = 16;
    localparam int RS_ID_WID   = $clog2(RS_SIZE);

    localparam logic [OP_WID-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OP_WID-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OP_WID-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OP_WID-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OP_WID-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OP_WID-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OP_WID-1:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                   valid;
        logic [ROB_POS_WID-1:0] tag;
        logic [31:0]            val;
    } bc_t;

    typedef struct packed {
        logic                   pending;
        logic [ROB_POS_WID-1:0] tag;
        logic [31:0]            val;
    } operand_t;

    typedef struct packed {
        logic [OP_WID-1:0]      opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        operand_t               op1;
        operand_t               op2;
        logic [31:0]            imm;
        logic [31:0]            pc;
        logic [ROB_POS_WID-1:0] rob_pos;
    } rs_entry_t;

    // ALU broadcast is checked first so it wins a (never expected) tag collision.
    function automatic operand_t snoop(input operand_t op, input bc_t alu, input bc_t lsb);
        operand_t r;
        r = op;
        if (op.pending) begin
            if (alu.valid && alu.tag == op.tag) begin
                r.pending = 1'b0;
                r.val     = alu.val;
            end else if (lsb.valid && lsb.tag == op.tag) begin
                r.pending = 1'b0;
                r.val     = lsb.val;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_prio_enc.sv
// ============================================================================
// Module      : rs_prio_enc
// Description : Lowest-set-bit priority encoder (request vector -> index, found).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_prio_enc #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module      : alu_rs
// Description : Reservation station for the integer ALU with broadcast snoop.
//               ALU_RS_WAKEUP_DISPATCH_EN: allow dispatch on the wakeup edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  issue_valid,
    input  logic [6:0]            issue_opcode,
    input  logic [2:0]            issue_funct3,
    input  logic                  issue_funct7,
    input  logic [31:0]           issue_val1,
    input  logic [31:0]           issue_val2,
    input  logic                  issue_has_dep1,
    input  logic                  issue_has_dep2,
    input  logic [ROB_POS_W-1:0]  issue_dep1,
    input  logic [ROB_POS_W-1:0]  issue_dep2,
    input  logic [31:0]           issue_imm,
    input  logic [31:0]           issue_pc,
    input  logic [ROB_POS_W-1:0]  issue_rob_pos,
    output logic                  rs_full,
    input  logic                  alu_bc,
    input  logic [ROB_POS_W-1:0]  alu_bc_rob_pos,
    input  logic [31:0]           alu_bc_val,
    input  logic                  lsb_bc,
    input  logic [ROB_POS_W-1:0]  lsb_bc_rob_pos,
    input  logic [31:0]           lsb_bc_val,
    output logic                  alu_en,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic                  funct7,
    output logic [31:0]           val1,
    output logic [31:0]           val2,
    output logic [31:0]           imm,
    output logic [31:0]           pc,
    output logic [ROB_POS_W-1:0]  rob_pos
);

    localparam int ID_W = $clog2(RS_SIZE);

    rs_entry_t          r_ent [RS_SIZE];
    logic [RS_SIZE-1:0] r_busy;

    bc_t                w_alu_bc;
    bc_t                w_lsb_bc;
    operand_t           w_op1 [RS_SIZE];
    operand_t           w_op2 [RS_SIZE];
    logic [RS_SIZE-1:0] w_ready;
    rs_entry_t          w_new;
    logic [ID_W-1:0]    w_free_idx;
    logic               w_free_found;
    logic [ID_W-1:0]    w_disp_idx;
    logic               w_disp_found;
    logic               w_do_issue;

    assign w_alu_bc = '{valid: alu_bc, tag: alu_bc_rob_pos, val: alu_bc_val};
    assign w_lsb_bc = '{valid: lsb_bc, tag: lsb_bc_rob_pos, val: lsb_bc_val};

    // Snooped operand view: stored state plus any broadcast seen this cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_op1[i] = snoop(r_ent[i].op1, w_alu_bc, w_lsb_bc);
            w_op2[i] = snoop(r_ent[i].op2, w_alu_bc, w_lsb_bc);
`ifdef ALU_RS_WAKEUP_DISPATCH_EN
            w_ready[i] = r_busy[i] & ~w_op1[i].pending & ~w_op2[i].pending;
`else
            w_ready[i] = r_busy[i] & ~r_ent[i].op1.pending & ~r_ent[i].op2.pending;
`endif
        end
    end

    always_comb begin
        w_new.opcode  = issue_opcode;
        w_new.funct3  = issue_funct3;
        w_new.funct7  = issue_funct7;
        w_new.op1     = snoop('{pending: issue_has_dep1, tag: issue_dep1, val: issue_val1},
                              w_alu_bc, w_lsb_bc);
        w_new.op2     = snoop('{pending: issue_has_dep2, tag: issue_dep2, val: issue_val2},
                              w_alu_bc, w_lsb_bc);
        w_new.imm     = issue_imm;
        w_new.pc      = issue_pc;
        w_new.rob_pos = issue_rob_pos;
    end

    rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
        .req   (~r_busy),
        .idx   (w_free_idx),
        .found (w_free_found)
    );

    rs_prio_enc #(.N(RS_SIZE)) u_disp_enc (
        .req   (w_ready),
        .idx   (w_disp_idx),
        .found (w_disp_found)
    );

    assign rs_full    = &r_busy;
    assign w_do_issue = issue_valid & w_free_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            alu_en  <= 1'b0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= 1'b0;
            val1    <= '0;
            val2    <= '0;
            imm     <= '0;
            pc      <= '0;
            rob_pos <= '0;
        end else if (rollback) begin
            r_busy <= '0;
            alu_en <= 1'b0;
        end else if (rdy) begin
            alu_en <= w_disp_found;
            if (w_disp_found) begin
                r_busy[w_disp_idx] <= 1'b0;
                opcode  <= r_ent[w_disp_idx].opcode;
                funct3  <= r_ent[w_disp_idx].funct3;
                funct7  <= r_ent[w_disp_idx].funct7;
                val1    <= w_op1[w_disp_idx].val;
                val2    <= w_op2[w_disp_idx].val;
                imm     <= r_ent[w_disp_idx].imm;
                pc      <= r_ent[w_disp_idx].pc;
                rob_pos <= r_ent[w_disp_idx].rob_pos;
            end
            if (w_do_issue) begin
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset: busy qualifies every use of it.
    always_ff @(posedge clk) begin
        if (!rollback && rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_ent[i].op1 <= w_op1[i];
                    r_ent[i].op2 <= w_op2[i];
                end
            end
            if (w_do_issue) begin
                r_ent[w_free_idx] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && !rollback && issue_valid) begin
            assert (!rs_full) else $error("alu_rs: issue while full, instruction dropped");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module      : tb_alu_rs
// Description : Directed self-checking bench for alu_rs with a dispatch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        issue_valid = 1'b0;
    logic [6:0]  issue_opcode = '0;
    logic [2:0]  issue_funct3 = '0;
    logic        issue_funct7 = 1'b0;
    logic [31:0] issue_val1 = '0, issue_val2 = '0, issue_imm = '0, issue_pc = '0;
    logic        issue_has_dep1 = 1'b0, issue_has_dep2 = 1'b0;
    logic [3:0]  issue_dep1 = '0, issue_dep2 = '0, issue_rob_pos = '0;
    logic        rs_full;
    logic        alu_bc = 1'b0, lsb_bc = 1'b0;
    logic [3:0]  alu_bc_rob_pos = '0, lsb_bc_rob_pos = '0;
    logic [31:0] alu_bc_val = '0, lsb_bc_val = '0;
    logic        alu_en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] val1, val2, imm, pc;
    logic [3:0]  rob_pos;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  rp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_rs #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
        .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
        .rs_full(rs_full),
        .alu_bc(alu_bc), .alu_bc_rob_pos(alu_bc_rob_pos), .alu_bc_val(alu_bc_val),
        .lsb_bc(lsb_bc), .lsb_bc_rob_pos(lsb_bc_rob_pos), .lsb_bc_val(lsb_bc_val),
        .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] im, input logic [31:0] p, input logic [3:0] rp);
        exp_t e;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.v1 = v1; e.v2 = v2;
        e.imm = im; e.pc = p; e.rp = rp;
        sbq.push_back(e);
    endtask

    // One clock edge, then compare any dispatch against the scoreboard head.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (alu_en === 1'b1) begin
            chk("disp_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("disp_opcode",  32'(opcode),  32'(e.opc));
                chk("disp_funct3",  32'(funct3),  32'(e.f3));
                chk("disp_funct7",  32'(funct7),  32'(e.f7));
                chk("disp_val1",    val1,         e.v1);
                chk("disp_val2",    val2,         e.v2);
                chk("disp_imm",     imm,          e.imm);
                chk("disp_pc",      pc,           e.pc);
                chk("disp_rob_pos", 32'(rob_pos), 32'(e.rp));
            end
        end
    endtask

    task automatic do_issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic hd1, input logic [3:0] d1,
                            input logic hd2, input logic [3:0] d2,
                            input logic [31:0] im, input logic [31:0] p, input logic [3:0] rp);
        issue_valid = 1'b1; issue_opcode = opc; issue_funct3 = f3; issue_funct7 = f7;
        issue_val1 = v1; issue_val2 = v2; issue_has_dep1 = hd1; issue_dep1 = d1;
        issue_has_dep2 = hd2; issue_dep2 = d2; issue_imm = im; issue_pc = p;
        issue_rob_pos = rp;
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_alu_en",  32'(alu_en),  32'd0);
        chk("rst_rs_full", 32'(rs_full), 32'd0);
        chk("rst_val1",    val1,         32'd0);
        chk("rst_pc",      pc,           32'd0);
        chk("rst_rob_pos", 32'(rob_pos), 32'd0);

        // ADDI with no dependencies
        push_exp(OPC_OP_IMM, 3'd0, 1'b0, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3);
        do_issue(OPC_OP_IMM, 3'd0, 1'b0, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd7, 32'h100, 4'd3);
        chk("addi_not_same_edge", 32'(alu_en), 32'd0);
        step();
        chk("addi_dispatch", 32'(alu_en), 32'd1);
        step();
        chk("addi_idle_after", 32'(alu_en), 32'd0);

        // ADD waiting on tag 2, woken by ALU broadcast two cycles later
        push_exp(OPC_OP, 3'd0, 1'b0, 32'h10, 32'd3, 32'd0, 32'h104, 4'd4);
        do_issue(OPC_OP, 3'd0, 1'b0, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'h104, 4'd4);
        chk("add_wait0", 32'(alu_en), 32'd0);
        step();
        chk("add_wait1", 32'(alu_en), 32'd0);
        alu_bc = 1'b1; alu_bc_rob_pos = 4'd2; alu_bc_val = 32'h10;
        step();
        alu_bc = 1'b0;
`ifdef ALU_RS_WAKEUP_DISPATCH_EN
        chk("add_wake_dispatch", 32'(alu_en), 32'd1);
`else
        chk("add_wake_edge", 32'(alu_en), 32'd0);
        step();
        chk("add_wake_dispatch", 32'(alu_en), 32'd1);
`endif
        step();
        chk("add_idle_after", 32'(alu_en), 32'd0);

        // Issue-time bypass from the LSB broadcast
        lsb_bc = 1'b1; lsb_bc_rob_pos = 4'd6; lsb_bc_val = 32'hABCD;
        push_exp(OPC_OP, 3'd7, 1'b1, 32'd1, 32'hABCD, 32'd0, 32'h108, 4'd5);
        do_issue(OPC_OP, 3'd7, 1'b1, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 32'd0, 32'h108, 4'd5);
        lsb_bc = 1'b0;
        chk("byp_not_same_edge", 32'(alu_en), 32'd0);
        step();
        chk("byp_dispatch", 32'(alu_en), 32'd1);
        step();

        // rdy low drops the issue
        rdy = 1'b0;
        do_issue(OPC_OP_IMM, 3'd0, 1'b0, 32'd9, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'h200, 4'd1);
        chk("stall_no_disp0", 32'(alu_en), 32'd0);
        rdy = 1'b1;
        step();
        chk("stall_no_disp1", 32'(alu_en), 32'd0);

        // Async reset mid-stream: three blocked entries plus a live dispatch
        for (int i = 0; i < 3; i++)
            do_issue(OPC_OP, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 32'h300, 4'(i));
        push_exp(OPC_OP_IMM, 3'd0, 1'b0, 32'd11, 32'd0, 32'd22, 32'h30C, 4'd8);
        do_issue(OPC_OP_IMM, 3'd0, 1'b0, 32'd11, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd22, 32'h30C, 4'd8);
        step();
        chk("mrst_pre_alu_en", 32'(alu_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_alu_en",  32'(alu_en),  32'd0);
        chk("mrst_val1",    val1,         32'd0);
        chk("mrst_imm",     imm,          32'd0);
        chk("mrst_pc",      pc,           32'd0);
        chk("mrst_rob_pos", 32'(rob_pos), 32'd0);
        chk("mrst_rs_full", 32'(rs_full), 32'd0);
        sbq.delete();
        #2 rst = 1'b0;
        alu_bc = 1'b1; alu_bc_rob_pos = 4'd1; alu_bc_val = 32'h5;
        step();
        alu_bc = 1'b0;
        chk("mrst_gone0", 32'(alu_en), 32'd0);
        step();
        chk("mrst_gone1", 32'(alu_en), 32'd0);

        // Fill all 16 entries blocked on tag 9, then release them
        for (int i = 0; i < 16; i++) begin
            push_exp(OPC_OP, 3'd0, 1'b0, 32'h900D, 32'(i), 32'(i), 32'h1000 + 32'(4 * i), 4'(i));
            do_issue(OPC_OP, 3'd0, 1'b0, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0,
                     32'(i), 32'h1000 + 32'(4 * i), 4'(i));
            if (i == 14) chk("fill_15_not_full", 32'(rs_full), 32'd0);
        end
        chk("fill_full", 32'(rs_full), 32'd1);
        alu_bc = 1'b1; alu_bc_rob_pos = 4'd9; alu_bc_val = 32'h900D;
        step();
        alu_bc = 1'b0;
`ifndef ALU_RS_WAKEUP_DISPATCH_EN
        chk("fill_wake_edge", 32'(alu_en), 32'd0);
        chk("fill_still_full", 32'(rs_full), 32'd1);
        step();
`endif
        chk("fill_first_disp", 32'(alu_en), 32'd1);
        chk("fill_full_drops", 32'(rs_full), 32'd0);
        for (int n = 0; n < 24 && sbq.size() != 0; n++) step();
        chk("fill_drained", 32'(sbq.size()), 32'd0);
        step();
        chk("fill_idle", 32'(alu_en), 32'd0);

        // Rollback with four busy entries and a concurrent issue
        for (int i = 0; i < 3; i++)
            do_issue(OPC_OP, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 32'h400, 4'(i));
        push_exp(OPC_OP_IMM, 3'd0, 1'b0, 32'd1, 32'd0, 32'd2, 32'h40C, 4'd7);
        do_issue(OPC_OP_IMM, 3'd0, 1'b0, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd2, 32'h40C, 4'd7);
        rollback = 1'b1;
        do_issue(OPC_OP_IMM, 3'd0, 1'b0, 32'd3, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd4, 32'h410, 4'd10);
        rollback = 1'b0;
        chk("rb_alu_en", 32'(alu_en), 32'd0);
        chk("rb_rs_full", 32'(rs_full), 32'd0);
        sbq.delete();
        alu_bc = 1'b1; alu_bc_rob_pos = 4'd12; alu_bc_val = 32'h77;
        step();
        alu_bc = 1'b0;
        chk("rb_empty0", 32'(alu_en), 32'd0);
        step();
        chk("rb_empty1", 32'(alu_en), 32'd0);

        chk("sb_empty_end", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
